// File: rtl/rfd_pulse_mon_pkg.sv
// Shared types and helpers for the RFD pulse monitor: FSM state encoding
// and the expected pulse period derived from the counter width.
package rfd_pulse_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  function automatic int unsigned period_of(input int unsigned nbits);
    return 32'd1 << nbits;
  endfunction

endpackage

// File: rtl/rfd_pulse_interval.sv
// Rising-edge detector and inter-pulse interval counter; classifies each
// event as good or early and flags a missing pulse at the end of a period.
module rfd_pulse_interval
  import rfd_pulse_mon_pkg::*;
#(
  parameter int unsigned NBITS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             hold,
  input  logic             pulse_in,
  output logic             ev,
  output logic             good,
  output logic             early,
  output logic             miss,
  output logic [NBITS:0]   icnt
);

  localparam int unsigned    P    = period_of(NBITS);
  localparam logic [NBITS:0] LAST = (NBITS+1)'(P - 1);

  logic           pulse_d_q, pulse_d_d;
  logic [NBITS:0] icnt_q, icnt_d;
  logic           ev_raw;

  always_comb begin
    pulse_d_d = pulse_in;
    ev_raw    = pulse_in & ~pulse_d_q;
    ev        = en & ev_raw;
    good      = ev & (icnt_q == LAST);
    early     = ev & (icnt_q < LAST);
    // A miss reloads the counter like a phantom pulse, so icnt never passes LAST.
    miss      = en & ~ev_raw & (icnt_q == LAST);
    if (!en || hold || ev || miss) begin
      icnt_d = '0;
    end else begin
      icnt_d = icnt_q + (NBITS+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_d_q <= 1'b0;
      icnt_q    <= '0;
    end else begin
      pulse_d_q <= pulse_d_d;
      icnt_q    <= icnt_d;
    end
  end

  assign icnt = icnt_q;

endmodule

// File: rtl/rfd_pulse_monitor.sv
// Health/alignment monitor for a 2^NBITS periodic pulse train: acquires lock,
// reports early or missing pulses while locked, and counts those errors.
module rfd_pulse_monitor
  import rfd_pulse_mon_pkg::*;
#(
  parameter int unsigned NBITS    = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             err_clr,
  input  logic             pulse_in,
  output logic             locked,
  output logic             pulse_err,
  output logic [ERR_W-1:0] err_count,
  output logic [NBITS:0]   period
);

  localparam int unsigned    GCW       = $clog2(LOCK_CNT + 1);
  localparam logic [GCW-1:0] LOCK_LAST = GCW'(LOCK_CNT - 1);

  mon_state_e       state_q, state_d;
  logic [GCW-1:0]   good_cnt_q, good_cnt_d;
  logic             locked_q, locked_d;
  logic             pulse_err_q, pulse_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [NBITS:0]   period_q, period_d;

  logic           ev, good, early, miss, err_ev;
  logic [NBITS:0] icnt;

  rfd_pulse_interval #(
    .NBITS(NBITS)
  ) u_interval (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .hold     (state_q == SEARCH),
    .pulse_in (pulse_in),
    .ev       (ev),
    .good     (good),
    .early    (early),
    .miss     (miss),
    .icnt     (icnt)
  );

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_ev     = 1'b0;
    if (!en) begin
      state_d    = SEARCH;
      good_cnt_d = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (ev) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
          end
        end
        ACQUIRE: begin
          if (good) begin
            good_cnt_d = good_cnt_q + GCW'(1);
            if (good_cnt_q == LOCK_LAST) state_d = LOCKED;
          end else if (early) begin
            good_cnt_d = '0;
          end else if (miss) begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (early || miss) begin
            err_ev     = 1'b1;
            state_d    = ACQUIRE;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = SEARCH;
          good_cnt_d = '0;
        end
      endcase
    end

    locked_d    = (state_d == LOCKED);
    pulse_err_d = err_ev;

    // A clear coincident with an error leaves that error counted.
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = err_ev ? ERR_W'(1) : '0;
    end else if (err_ev && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end

    period_d = ev ? (icnt + (NBITS+1)'(1)) : period_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SEARCH;
      good_cnt_q  <= '0;
      locked_q    <= 1'b0;
      pulse_err_q <= 1'b0;
      err_count_q <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= locked_d;
      pulse_err_q <= pulse_err_d;
      err_count_q <= err_count_d;
      period_q    <= period_d;
    end
  end

  assign locked    = locked_q;
  assign pulse_err = pulse_err_q;
  assign err_count = err_count_q;
  assign period    = period_q;

endmodule

// File: tb/tb_rfd_pulse_monitor.sv
// Directed bench for rfd_pulse_monitor: lock, miss, early, saturation/clear,
// stuck-high, enable and async reset, on an 8-bit and a 2-bit error counter.
module tb_rfd_pulse_monitor;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic en = 1'b0;
  logic err_clr = 1'b0;
  logic pulse_in = 1'b0;

  logic       locked, pulse_err, locked_s, pulse_err_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;
  logic [4:0] period, period_s;

  int total = 0;
  int bad = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  rfd_pulse_monitor #(.NBITS(4), .LOCK_CNT(4), .ERR_W(8)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .err_clr(err_clr), .pulse_in(pulse_in),
    .locked(locked), .pulse_err(pulse_err), .err_count(err_count), .period(period)
  );

  rfd_pulse_monitor #(.NBITS(4), .LOCK_CNT(4), .ERR_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .err_clr(err_clr), .pulse_in(pulse_in),
    .locked(locked_s), .pulse_err(pulse_err_s), .err_count(err_count_s), .period(period_s)
  );

  always @(negedge clk) if (pulse_err === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    level(1'b0, n);
  endtask

  task automatic pulse();
    level(1'b1, 1);
    pulse_in = 1'b0;
  endtask

  // n pulses, each 16 cycles after the previous one
  task automatic train(input int n);
    for (int i = 0; i < n; i++) begin
      idle(15);
      pulse();
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    #2;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pulse_err", 32'(pulse_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_sat_all", {locked_s, pulse_err_s, err_count_s, period_s}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;

    // lock acquire
    idle(10);
    pulse();
    chk("acq_first_period", 32'(period), 1);
    chk("acq_first_locked", 32'(locked), 0);
    train(3);
    chk("acq_4th_locked", 32'(locked), 0);
    chk("acq_4th_period", 32'(period), 16);
    train(1);
    chk("acq_locked", 32'(locked), 1);
    chk("acq_period", 32'(period), 16);
    chk("acq_no_strobe", 32'(strobes), 0);

    // missing pulse
    idle(16);
    chk("miss_pulse_err", 32'(pulse_err), 1);
    chk("miss_locked", 32'(locked), 0);
    chk("miss_err_count", 32'(err_count), 1);
    chk("miss_period_held", 32'(period), 16);
    idle(1);
    chk("miss_strobe_len", 32'(pulse_err), 0);
    idle(14);
    pulse();
    train(2);
    chk("miss_relock_early", 32'(locked), 0);
    train(1);
    chk("miss_relock", 32'(locked), 1);
    chk("miss_strobes", 32'(strobes), 1);

    // early pulse, then the regular pulse is early as well
    idle(7);
    pulse();
    chk("early_pulse_err", 32'(pulse_err), 1);
    chk("early_period", 32'(period), 8);
    chk("early_locked", 32'(locked), 0);
    chk("early_err_count", 32'(err_count), 2);
    chk("early_sat_count", 32'(err_count_s), 2);
    idle(7);
    pulse();
    chk("early2_pulse_err", 32'(pulse_err), 0);
    chk("early2_period", 32'(period), 8);
    train(3);
    chk("early_relock_early", 32'(locked), 0);
    train(1);
    chk("early_relock", 32'(locked), 1);
    chk("early_strobes", 32'(strobes), 2);

    // errors 3..5: 8-bit counter keeps counting, 2-bit saturates at 3
    for (int k = 0; k < 3; k++) begin
      idle(7);
      pulse();
      chk("sat_pulse_err", 32'(pulse_err), 1);
      chk("sat_err8", 32'(err_count), 32'(3 + k));
      chk("sat_err2", 32'(err_count_s), 3);
      train(4);
      chk("sat_relock", 32'(locked), 1);
    end

    // clear coincident with a 6th error, then clear alone
    idle(7);
    err_clr = 1'b1;
    pulse();
    err_clr = 1'b0;
    chk("clr_err_pulse_err", 32'(pulse_err), 1);
    chk("clr_err_err8", 32'(err_count), 1);
    chk("clr_err_err2", 32'(err_count_s), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("clr_err8", 32'(err_count), 0);
    chk("clr_err2", 32'(err_count_s), 0);
    idle(14);
    pulse();
    train(3);
    chk("clr_relock", 32'(locked), 1);
    chk("clr_strobes", 32'(strobes), 6);

    // stuck high for 40 cycles starting at a regular slot
    idle(15);
    level(1'b1, 17);
    chk("stuck_pulse_err", 32'(pulse_err), 1);
    chk("stuck_locked", 32'(locked), 0);
    chk("stuck_err_count", 32'(err_count), 1);
    chk("stuck_period", 32'(period), 16);
    level(1'b1, 1);
    chk("stuck_strobe_len", 32'(pulse_err), 0);
    level(1'b1, 22);
    idle(5);
    pulse();
    chk("stuck_search_period", 32'(period), 1);
    chk("stuck_strobes", 32'(strobes), 7);
    train(4);
    chk("stuck_relock", 32'(locked), 1);

    // enable drop while locked
    idle(3);
    en = 1'b0;
    idle(1);
    chk("en_locked", 32'(locked), 0);
    chk("en_err_count", 32'(err_count), 1);
    chk("en_pulse_err", 32'(pulse_err), 0);
    pulse();
    chk("en_period_held", 32'(period), 16);
    idle(3);
    level(1'b1, 1);
    en = 1'b1;
    level(1'b1, 1);
    idle(10);
    pulse();
    chk("en_rise_period", 32'(period), 1);
    train(4);
    chk("en_relock", 32'(locked), 1);
    chk("en_strobes", 32'(strobes), 7);

    // async reset mid-interval while locked
    idle(5);
    #2 rstn = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_err_count", 32'(err_count), 0);
    chk("arst_period", 32'(period), 0);
    chk("arst_sat_all", {locked_s, pulse_err_s, err_count_s, period_s}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle(10);
    pulse();
    chk("arst_first_period", 32'(period), 1);
    train(3);
    chk("arst_4th_locked", 32'(locked), 0);
    train(1);
    chk("arst_locked_again", 32'(locked), 1);
    chk("arst_period_again", 32'(period), 16);
    chk("arst_sat_locked", 32'(locked_s), 1);
    chk("arst_strobes", 32'(strobes), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfd_pulse_monitor.md
Name: rfd_pulse_monitor

Overview:
Receive-side companion to the RFD periodic pulse generator. It consumes a 1-cycle pulse train that should arrive every 2^NBITS clk cycles. It measures the interval between pulses, acquires and declares lock after LOCK_CNT consecutive correct intervals, and flags early or missing pulses. It sits beside the generator's consumer, in the same clk domain, as a health and alignment monitor.

Parameters:
- NBITS, 4: expected period P = 2^NBITS cycles. Must be >= 2.
- LOCK_CNT, 4: consecutive good intervals required to enter LOCKED. Must be >= 1.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: asynchronous, active-low reset.
- en, input, 1: monitor enable. When 0, the block is held in SEARCH.
- err_clr, input, 1: synchronous clear of err_count.
- pulse_in, input, 1: pulse train, synchronous to clk.
- locked, output, 1: registered; high while state is LOCKED.
- pulse_err, output, 1: registered 1-cycle strobe on an early or missing pulse in LOCKED.
- err_count, output, ERR_W: saturating count of pulse_err strobes.
- period, output, NBITS+1: last measured interval in cycles, registered.

Behaviour:
Reset and outputs
- rstn low (async): state=SEARCH; locked=0, pulse_err=0, err_count=0, period=0.
- All internal registers are also cleared: pulse_d, icnt, good_cnt.

Event detection and interval counter
- Event: ev = pulse_in & ~pulse_d, where pulse_d is pulse_in registered. Only rising edges count; a multi-cycle-high input is a single event.
- icnt is NBITS+1 bits wide. It is cleared to 0 on an ev cycle and increments on every other cycle.
- Good event: ev with icnt == P-1. Early event: ev with icnt < P-1.
- Miss: a cycle with no ev and icnt == P-1. On a miss, icnt reloads 0, as for a phantom pulse, so a persistent absence raises a miss every P cycles. icnt therefore never exceeds P-1.
- On every ev, period <= icnt+1. Misses do not update period.

FSM
States are SEARCH, ACQUIRE, LOCKED. All transitions happen at the clk edge closing the detecting cycle; outputs are visible the next cycle (latency 1).
- SEARCH: icnt is held at 0. On the first ev: go to ACQUIRE, good_cnt=0. No error is reported.
- ACQUIRE:
  - Good ev: good_cnt+1. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - Early ev: good_cnt=0, stay in ACQUIRE; no pulse_err.
  - Miss: go to SEARCH.
- LOCKED:
  - Good ev: stay.
  - Early ev or miss: pulse_err=1 for one cycle, err_count increments, go to ACQUIRE with good_cnt=0.

Error counter
- err_count saturates at 2^ERR_W-1.
- err_clr and an error in the same cycle: err_count=1.
- err_clr alone: err_count=0.

Enable
- en=0: synchronous return to SEARCH; icnt=0, good_cnt=0, pulse_err=0.
- err_count and period are held.
- ev during en=0 is ignored, but pulse_d keeps tracking pulse_in, so a pulse that is high when en rises is not counted.

Reset mid-operation
- Async rstn takes effect immediately. After release the block restarts in SEARCH.

Decomposition:
- Package rfd_pulse_mon_pkg: state enum (SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2); a localparam function computing P from NBITS.
- Sub-module rfd_pulse_interval: edge detect plus icnt. Outputs ev, good, early and miss. The FSM and error counter stay in the top level.

Test Plan:
All scenarios use NBITS=4, LOCK_CNT=4.
- Lock acquire: clean pulses every 16 cycles starting at cycle 10 -> locked rises 1 cycle after the 5th pulse (cycle 75); period=16; pulse_err never asserted.
- Missing pulse: when LOCKED, drop the pulse due at cycle N -> pulse_err at N+1 for exactly 1 cycle; locked=0 at N+1; err_count=1; relock 1 cycle after 4 further good pulses.
- Early pulse: when LOCKED, an extra pulse 8 cycles after the last -> pulse_err 1 cycle, period=8, state ACQUIRE. The regular pulse 8 cycles later is counted as early too: period=8, no strobe, good_cnt stays 0.
- Saturation and clear: ERR_W=2, force 5 errors -> err_count stays at 3; assert err_clr coincident with a 6th error -> err_count=1.
- Stuck-high and enable: hold pulse_in high for 40 cycles while LOCKED -> one ev, then misses; pulse_err at the first miss, then state goes to SEARCH. Separately, drop en while LOCKED -> locked=0 next cycle and err_count is unchanged.
- Async reset: assert rstn low mid-interval while LOCKED -> all outputs 0 immediately, without a clock edge; after release, behaviour is identical to the lock-acquire scenario.
